// File: rtl/bram_sync_pkg.sv
// Shared types and constants for the backup-RAM save/load sequencer.
package bram_sync_pkg;

   localparam int SECTORS_DEFAULT = 128;
   localparam int LBA_W           = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2
   } state_e;

endpackage

// File: rtl/bram_sync.sv
// Backup-RAM save/load sequencer: walks the save image one SD sector at a time
// and owns the bk_ena, autosave-pending and loading flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transfer; waiting for a load or save trigger
// ST_REQ  | sd_rd or sd_wr asserted, waiting for sd_ack to rise
// ST_XFER | sector acknowledged, waiting for sd_ack to fall
module bram_sync
   import bram_sync_pkg::*;
#(
   parameter int SECTORS     = SECTORS_DEFAULT,
   parameter int ACK_TIMEOUT = 0
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             downloading,
   input  logic             img_mounted,
   input  logic             img_readonly,
   input  logic             img_present,
   input  logic             load_req,
   input  logic             save_req,
   input  logic             autosave_en,
   input  logic             osd_status,
   input  logic             bk_change,
   input  logic             sd_ack,
   output logic [LBA_W-1:0] sd_lba,
   output logic             sd_rd,
   output logic             sd_wr,
   output logic             bk_ena,
   output logic             bk_loading,
   output logic             bk_busy,
   output logic             sav_pending,
   output logic             err
);

   localparam int              CNT_W       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
   localparam bit              WD_EN       = (ACK_TIMEOUT != 0);
   localparam logic [6:0]      LAST_SECTOR = 7'(SECTORS - 1);

   state_e             state_q, state_d;
   logic [LBA_W-1:0]   sd_lba_q, sd_lba_d;
   logic               sd_rd_q, sd_rd_d;
   logic               sd_wr_q, sd_wr_d;
   logic               bk_ena_q, bk_ena_d;
   logic               bk_loading_q, bk_loading_d;
   logic               bk_busy_q, bk_busy_d;
   logic               sav_pending_q, sav_pending_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;

   logic               dl_old_q, dl_old_d;
   logic               load_old_q, load_old_d;
   logic               save_old_q, save_old_d;
   logic               ack_old_q, ack_old_d;
   logic               as_old_q, as_old_d;

   logic               dl_rise, dl_fall, load_rise, save_rise;
   logic               ack_rise, ack_fall, as_term, as_rise;
   logic               load_start, save_start;

   always_comb begin
      as_term   = sav_pending_q & osd_status & autosave_en;
      dl_rise   = downloading & ~dl_old_q;
      dl_fall   = ~downloading & dl_old_q;
      load_rise = load_req & ~load_old_q;
      save_rise = save_req & ~save_old_q;
      ack_rise  = sd_ack & ~ack_old_q;
      ack_fall  = ~sd_ack & ack_old_q;
      as_rise   = as_term & ~as_old_q;

      // Load outranks save when both fire in the same cycle.
      load_start = bk_ena_q & ((dl_fall & img_present) | load_rise);
      save_start = bk_ena_q & (save_rise | as_rise) & ~load_start;

      dl_old_d   = downloading;
      load_old_d = load_req;
      save_old_d = save_req;
      ack_old_d  = sd_ack;
      as_old_d   = as_term;

      state_d      = state_q;
      sd_lba_d     = sd_lba_q;
      sd_rd_d      = sd_rd_q;
      sd_wr_d      = sd_wr_q;
      bk_loading_d = bk_loading_q;
      bk_busy_d    = bk_busy_q;
      err_d        = err_q;
      wd_cnt_d     = '0;

      bk_ena_d = bk_ena_q;
      if (dl_rise)
         bk_ena_d = 1'b0;
      if (downloading & img_mounted & ~img_readonly)
         bk_ena_d = 1'b1;

      sav_pending_d = sav_pending_q;
      if (bk_change & ~osd_status)
         sav_pending_d = 1'b1;
      else if (bk_busy_q)
         sav_pending_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load_start | save_start) begin
               state_d      = ST_REQ;
               sd_lba_d     = '0;
               bk_busy_d    = 1'b1;
               err_d        = 1'b0;
               sd_rd_d      = load_start;
               sd_wr_d      = ~load_start;
               bk_loading_d = load_start;
            end
         end
         ST_REQ: begin
            if (dl_rise) begin
               state_d      = ST_IDLE;
               sd_rd_d      = 1'b0;
               sd_wr_d      = 1'b0;
               bk_busy_d    = 1'b0;
               bk_loading_d = 1'b0;
            end else if (ack_rise) begin
               state_d = ST_XFER;
               sd_rd_d = 1'b0;
               sd_wr_d = 1'b0;
            end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
               state_d      = ST_IDLE;
               err_d        = 1'b1;
               sd_rd_d      = 1'b0;
               sd_wr_d      = 1'b0;
               bk_busy_d    = 1'b0;
               bk_loading_d = 1'b0;
            end else begin
               wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
         end
         ST_XFER: begin
            if (dl_rise) begin
               state_d      = ST_IDLE;
               sd_rd_d      = 1'b0;
               sd_wr_d      = 1'b0;
               bk_busy_d    = 1'b0;
               bk_loading_d = 1'b0;
            end else if (ack_fall) begin
               if (sd_lba_q[6:0] == LAST_SECTOR) begin
                  state_d      = ST_IDLE;
                  bk_busy_d    = 1'b0;
                  bk_loading_d = 1'b0;
               end else begin
                  // bk_loading doubles as the direction memory for the next sector.
                  state_d  = ST_REQ;
                  sd_lba_d = sd_lba_q + LBA_W'(1);
                  sd_rd_d  = bk_loading_q;
                  sd_wr_d  = ~bk_loading_q;
               end
            end
         end
         default: begin
            state_d      = ST_IDLE;
            sd_rd_d      = 1'b0;
            sd_wr_d      = 1'b0;
            bk_busy_d    = 1'b0;
            bk_loading_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         sd_lba_q      <= '0;
         sd_rd_q       <= 1'b0;
         sd_wr_q       <= 1'b0;
         bk_ena_q      <= 1'b0;
         bk_loading_q  <= 1'b0;
         bk_busy_q     <= 1'b0;
         sav_pending_q <= 1'b0;
         err_q         <= 1'b0;
         wd_cnt_q      <= '0;
         dl_old_q      <= 1'b0;
         load_old_q    <= 1'b0;
         save_old_q    <= 1'b0;
         ack_old_q     <= 1'b0;
         as_old_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         sd_lba_q      <= sd_lba_d;
         sd_rd_q       <= sd_rd_d;
         sd_wr_q       <= sd_wr_d;
         bk_ena_q      <= bk_ena_d;
         bk_loading_q  <= bk_loading_d;
         bk_busy_q     <= bk_busy_d;
         sav_pending_q <= sav_pending_d;
         err_q         <= err_d;
         wd_cnt_q      <= wd_cnt_d;
         dl_old_q      <= dl_old_d;
         load_old_q    <= load_old_d;
         save_old_q    <= save_old_d;
         ack_old_q     <= ack_old_d;
         as_old_q      <= as_old_d;
      end
   end

   assign sd_lba      = sd_lba_q;
   assign sd_rd       = sd_rd_q;
   assign sd_wr       = sd_wr_q;
   assign bk_ena      = bk_ena_q;
   assign bk_loading  = bk_loading_q;
   assign bk_busy     = bk_busy_q;
   assign sav_pending = sav_pending_q;
   assign err         = err_q;

endmodule

// File: doc/bram_sync.md
Name: bram_sync

Overview:
Backup-RAM save/load sequencer for the Genesis core. It sits between the hps_io SD sector interface and the system BRAM port. It sequences an SD request and acknowledge exchange for each 512-byte sector across the save image, and it owns the bk_ena, autosave-pending and loading flags. bk_loading drives the core reset term in emu, and sd_lba[6:0] forms the upper BRAM address.

Parameters:
SECTORS, 128, sectors per save image; the last LBA is SECTORS-1; must be a power of two, 2..128.
ACK_TIMEOUT, 0, clk_sys cycles to wait for sd_ack to rise before aborting; 0 disables the watchdog.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
downloading  in  1  ROM download in progress (ioctl_download)
img_mounted  in  1  save image mounted pulse
img_readonly  in  1  mounted image is read-only
img_present  in  1  image size is non-zero (|img_size)
load_req  in  1  manual load request, level (OSD status bit)
save_req  in  1  manual save request, level (OSD status bit)
autosave_en  in  1  autosave option enabled
osd_status  in  1  OSD menu open
bk_change  in  1  core has written BRAM (pulse)
sd_ack  in  1  hps_io sector acknowledge
sd_lba  out  32  sector LBA
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
bk_ena  out  1  save image usable
bk_loading  out  1  load in progress (holds the core in reset)
bk_busy  out  1  transfer in progress
sav_pending  out  1  unsaved BRAM changes exist
err  out  1  last transfer aborted by the ack watchdog

Behaviour:
- Reset values: all outputs 0, state IDLE, edge registers 0. Reset is asynchronous and acts at any point, including mid-transfer.
- Edge detection: each of downloading, load_req, save_req, sd_ack and the autosave term has a one-cycle registered copy. Rise = input & ~old; fall = ~input & old.
- Autosave term: sav_pending & osd_status & autosave_en. A rise of this term counts as a save trigger.
- bk_ena: cleared on a downloading rise. Set while downloading & img_mounted & ~img_readonly. If both occur in one cycle, set wins.
- sav_pending: set on bk_change & ~osd_status; otherwise cleared while bk_busy. Set wins on a tie.
- States: IDLE, REQ (rd/wr asserted, awaiting ack rise), XFER (ack high, awaiting ack fall).
- IDLE start conditions, priority high to low:
  - downloading fall & img_present & bk_ena -> load.
  - load_req rise & bk_ena -> load.
  - save trigger & bk_ena -> save.
  - A simultaneous load and save start is a load.
- On start:
  - sd_lba <= 0, state REQ, bk_busy <= 1, err <= 0.
  - Load: sd_rd <= 1, sd_wr <= 0, bk_loading <= 1.
  - Save: sd_wr <= 1, sd_rd <= 0, bk_loading <= 0.
  - Outputs are visible the cycle after the triggering input change.
- REQ:
  - On sd_ack rise: sd_rd and sd_wr <= 0, go to XFER. Outputs drop the cycle after ack is first seen high.
  - Watchdog: a counter runs in REQ. If ACK_TIMEOUT != 0 and the count reaches ACK_TIMEOUT, then err <= 1, rd/wr <= 0, bk_busy and bk_loading <= 0, go to IDLE.
- XFER, on sd_ack fall:
  - If sd_lba[6:0] == SECTORS-1: go to IDLE, bk_busy and bk_loading <= 0.
  - Otherwise: sd_lba <= sd_lba+1, reassert the same direction, go to REQ.
  - LBA never wraps; only bits [6:0] are compared.
- sd_rd and sd_wr are never high together. Neither is ever high in IDLE.
- A downloading rise in any non-IDLE state aborts the transfer:
  - rd/wr <= 0, bk_busy and bk_loading <= 0, go to IDLE.
  - bk_ena is cleared; err is unchanged.
- Trigger edges that arrive while busy are discarded, not queued.
- sd_ack that is high on entry to IDLE is ignored until a new start.

Decomposition:
- Package bram_sync_pkg holds:
  - the state enum (IDLE, REQ, XFER);
  - the default SECTORS constant;
  - the LBA width constant (32).
- No sub-module. Edge detectors and the watchdog counter stay inline.

Test Plan:
1. Mount rw image during download, then drop downloading with img_present=1 -> bk_loading and sd_rd high next cycle, lba=0. Ack 128 rise/fall pairs -> lba walks 0..127, rd reasserts after each fall, bk_loading=0 after the 128th fall.
2. bk_change with osd_status=0 -> sav_pending=1. Set autosave_en=1, then raise osd_status -> sd_wr=1, sav_pending clears the next cycle, 128 sectors written.
3. load_req and save_req rise in the same cycle with bk_ena=1 -> load (sd_rd=1, sd_wr=0). With bk_ena=0 -> no request.
4. ACK_TIMEOUT=16 and sd_ack held low -> err=1 at the 16th REQ cycle, sd_rd=0, bk_busy=0. A following load_req rise clears err.
5. Mid-save at lba=40, raise downloading -> rd/wr=0, bk_busy=0, bk_ena=0 the next cycle.
6. Assert reset_n=0 asynchronously mid-load -> all outputs 0 immediately, no clock needed.
